// File: rtl/upsample_pkg.sv
// Shared definitions for the upsample replay FIFO.
// Contents:
//   DEF_* localparams     default widths and thresholds used by the FIFO and its RAM
//   clog2()               constant log2 (ceiling) used to derive pointer widths
//   ratio_legal()         the set of supported write/read width ratios
package upsample_pkg;

  localparam int DEF_DATA_W       = 256;
  localparam int DEF_RATIO        = 2;
  localparam int DEF_DEPTH_W      = 10;
  localparam int DEF_AF_THRESHOLD = 1000;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << r) < value) r = r + 1;
    end
    return r;
  endfunction

  function automatic bit ratio_legal(input int ratio);
    return (ratio == 1) || (ratio == 2) || (ratio == 4) || (ratio == 8);
  endfunction

endpackage

// File: rtl/upsample_sdp_ram.sv
// Simple dual-port word store for the upsample replay FIFO.
// Ports:
//   clk      in   clock, rising edge
//   rst_n    in   asynchronous active-low reset (clears the read register only)
//   wr_en    in   write strobe
//   wr_addr  in   write word address
//   wr_data  in   write word
//   rd_en    in   read strobe; rd_data holds when low
//   rd_addr  in   read word address
//   rd_data  out  registered read word, valid the cycle after rd_en
module upsample_sdp_ram
  import upsample_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_DEPTH_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/upsample_replay_fifo.sv
// Width-converting FIFO with mark/rewind replay, used to repeat image rows
// for vertical upsampling. Wide words are written, narrow slices are read;
// data behind the mark is held so the reader can rewind to it any number of
// times.
// Ports:
//   system_clk, rst_n          clock / asynchronous active-low reset
//   i_wren, i_wrdata           write request and DATA_W word
//   o_full, o_almost_full      no word space / committed words >= threshold
//   i_rden                     read request (one DATA_R slice)
//   o_rddata, o_rdvalid        slice and its one-cycle strobe (cycle after read)
//   o_empty, o_almost_empty    no unread slice / level below threshold
//   i_almost_empty_threshold   almost-empty threshold in slices
//   i_mark                     commit read position, freeing consumed words
//   i_rewind                   return read position to the mark
//   o_level, o_committed       unread slices / slices held behind the mark
module upsample_replay_fifo
  import upsample_pkg::*;
#(
  parameter  int DATA_W                = DEF_DATA_W,
  parameter  int RATIO                 = DEF_RATIO,
  parameter  int DEPTH_W               = DEF_DEPTH_W,
  parameter  int ALMOST_FULL_THRESHOLD = DEF_AF_THRESHOLD,
  localparam int DATA_R                = DATA_W / RATIO,
  localparam int DEPTH_R               = DEPTH_W + clog2(RATIO)
) (
  input  logic               system_clk,
  input  logic               rst_n,
  input  logic               i_wren,
  input  logic [DATA_W-1:0]  i_wrdata,
  output logic               o_full,
  output logic               o_almost_full,
  input  logic               i_rden,
  output logic [DATA_R-1:0]  o_rddata,
  output logic               o_rdvalid,
  output logic               o_empty,
  output logic               o_almost_empty,
  input  logic [DEPTH_R:0]   i_almost_empty_threshold,
  input  logic               i_mark,
  input  logic               i_rewind,
  output logic [DEPTH_R:0]   o_level,
  output logic [DEPTH_R:0]   o_committed
);

  localparam int LOG2R = clog2(RATIO);
  localparam int PW    = DEPTH_R + 1;
  localparam int SEL_W = (LOG2R > 0) ? LOG2R : 1;
  // Highest committed level at which one more whole word still fits.
  localparam logic [PW-1:0] FULL_LIM = PW'((1 << DEPTH_R) - RATIO);

  if (!ratio_legal(RATIO) || (DATA_W % RATIO) != 0) begin : g_bad_ratio
    $error("upsample_replay_fifo: illegal RATIO/DATA_W combination");
  end

  logic [PW-1:0]    wr_ptr, rd_ptr, mark_ptr, rd_next;
  logic             wr_acc, rd_acc;
  logic [SEL_W-1:0] sel_d, sel_q;
  logic [PW-1:0]    cmt_words;
  logic [DATA_W-1:0] ram_q;
  logic [RATIO-1:0][DATA_R-1:0] slices;

  assign o_level     = wr_ptr - rd_ptr;
  assign o_committed = wr_ptr - mark_ptr;
  assign o_full      = o_committed > FULL_LIM;
  assign o_empty     = (o_level == '0);
  assign cmt_words   = o_committed >> LOG2R;
  assign o_almost_full  = int'(cmt_words) >= ALMOST_FULL_THRESHOLD;
  assign o_almost_empty = o_level < i_almost_empty_threshold;

  assign wr_acc = i_wren & ~o_full;
  // Rewind wins over read; an empty FIFO never forwards a same-cycle write.
  assign rd_acc = i_rden & ~o_empty & ~i_rewind;

  always_comb begin
    rd_next = rd_ptr;
    if (i_rewind)    rd_next = mark_ptr;
    else if (rd_acc) rd_next = rd_ptr + PW'(1);
  end

  assign sel_d = (RATIO > 1) ? rd_ptr[SEL_W-1:0] : '0;

  always_ff @(posedge system_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      mark_ptr  <= '0;
      o_rdvalid <= 1'b0;
      sel_q     <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PW'(RATIO);
      rd_ptr <= rd_next;
      // Mark captures the post-read position so a read+mark frees that slice.
      if (i_mark && !i_rewind) mark_ptr <= rd_next;
      o_rdvalid <= rd_acc;
      if (rd_acc) sel_q <= sel_d;
    end
  end

  // The word holding the slice being read is fetched on the accepted read;
  // it was written in an earlier cycle, so there is no read/write collision.
  upsample_sdp_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (DEPTH_W)
  ) u_ram (
    .clk     (system_clk),
    .rst_n   (rst_n),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr[DEPTH_R-1:LOG2R]),
    .wr_data (i_wrdata),
    .rd_en   (rd_acc),
    .rd_addr (rd_ptr[DEPTH_R-1:LOG2R]),
    .rd_data (ram_q)
  );

  assign slices   = ram_q;
  assign o_rddata = slices[sel_q];

endmodule
